// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request ports 0/1 plus the synchronous dmem side of dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_wren;
    logic [ADDR_W-1:0] p0_address;
    logic [DATA_W-1:0] p0_data;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_q;

    logic              p1_req;
    logic              p1_wren;
    logic [ADDR_W-1:0] p1_address;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_q;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic              busy;

    modport slave (
        input  p0_req, p0_wren, p0_address, p0_data,
        output p0_ack, p0_q,
        input  p1_req, p1_wren, p1_address, p1_data,
        output p1_ack, p1_q,
        output mem_address, mem_data, mem_wren,
        input  mem_q,
        output busy
    );

    modport master (
        output p0_req, p0_wren, p0_address, p0_data,
        input  p0_ack, p0_q,
        output p1_req, p1_wren, p1_address, p1_data,
        input  p1_ack, p1_q,
        input  mem_address, mem_data, mem_wren,
        output mem_q,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a synchronous dmem, one access per 3 cycles
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              elig0, elig1, pick;

    // A port in its ack cycle is not eligible, so a req held through the ack is not re-served.
    assign elig0 = bus.p0_req & ~p0_ack_q;
    assign elig1 = bus.p1_req & ~p1_ack_q;

    always_comb begin
        if (elig0 && elig1) begin
            pick = (FIXED_PRI != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            pick = elig1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        data_d       = data_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    wren_d       = pick ? bus.p1_wren    : bus.p0_wren;
                    addr_d       = pick ? bus.p1_address : bus.p0_address;
                    data_d       = pick ? bus.p1_data    : bus.p0_data;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_DONE;
            S_DONE: begin
                if (!wren_q) begin
                    if (grant_q) p1_rdata_d = bus.mem_q;
                    else         p0_rdata_d = bus.mem_q;
                end
                p0_ack_d = ~grant_q;
                p1_ack_d = grant_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // Latched values only change on a grant, so the dmem bus holds its last access outside ISSUE.
    // Reset gates the write strobe so an access aborted in ISSUE never lands in memory.
    assign bus.mem_address = addr_q;
    assign bus.mem_data    = data_q;
    assign bus.mem_wren    = (state_q == S_ISSUE) & wren_q & ~reset;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.p0_ack      = p0_ack_q;
    assign bus.p1_ack      = p1_ack_q;
    assign bus.p0_q        = p0_rdata_q;
    assign bus.p1_q        = p1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter, round-robin and fixed-priority builds
module tb_dmem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_init;
    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] tr_a, tr_b;
    logic        ack_seen;

    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) dut_rr (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) dut_fp (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
    );

    assign ifb.p0_req     = ifa.p0_req;
    assign ifb.p0_wren    = ifa.p0_wren;
    assign ifb.p0_address = ifa.p0_address;
    assign ifb.p0_data    = ifa.p0_data;
    assign ifb.p1_req     = ifa.p1_req;
    assign ifb.p1_wren    = ifa.p1_wren;
    assign ifb.p1_address = ifa.p1_address;
    assign ifb.p1_data    = ifa.p1_data;

    // Synchronous dmem models; word i powers up as 0x1000_0000 + i.
    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'h1000_0000 + i;
        end else if (ifa.mem_wren) begin
            mem_a[ifa.mem_address[7:0]] <= ifa.mem_data;
        end
        ifa.mem_q <= mem_a[ifa.mem_address[7:0]];
    end

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'h1000_0000 + i;
        end else if (ifb.mem_wren) begin
            mem_b[ifb.mem_address[7:0]] <= ifb.mem_data;
        end
        ifb.mem_q <= mem_b[ifb.mem_address[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        mem_init       = 1'b1;
        reset          = 1'b1;
        ifa.p0_req     = 1'b0;
        ifa.p0_wren    = 1'b0;
        ifa.p0_address = '0;
        ifa.p0_data    = '0;
        ifa.p1_req     = 1'b0;
        ifa.p1_wren    = 1'b0;
        ifa.p1_address = '0;
        ifa.p1_data    = '0;
        repeat (3) @(negedge clock);

        check("rst_busy",   ifa.busy,        32'd0);
        check("rst_wren",   ifa.mem_wren,    32'd0);
        check("rst_addr",   ifa.mem_address, 32'd0);
        check("rst_data",   ifa.mem_data,    32'd0);
        check("rst_ack0",   ifa.p0_ack,      32'd0);
        check("rst_ack1",   ifa.p1_ack,      32'd0);
        check("rst_q0",     ifa.p0_q,        32'd0);
        check("rst_q1",     ifa.p1_q,        32'd0);
        check("rst_busy_fp", ifb.busy,       32'd0);
        mem_init = 1'b0;
        reset    = 1'b0;
        @(negedge clock);

        // p0 write 0x010 <- DEADBEEF, req held through the ack cycle
        ifa.p0_req = 1'b1; ifa.p0_wren = 1'b1; ifa.p0_address = 12'h010; ifa.p0_data = 32'hDEAD_BEEF;
        @(negedge clock);
        check("wr_issue_wren", ifa.mem_wren,    32'd1);
        check("wr_issue_addr", ifa.mem_address, 32'h010);
        check("wr_issue_data", ifa.mem_data,    32'hDEAD_BEEF);
        check("wr_issue_busy", ifa.busy,        32'd1);
        ifa.p0_address = 12'h3FF; ifa.p0_data = 32'h0;
        @(negedge clock);
        check("wr_done_wren", ifa.mem_wren,    32'd0);
        check("wr_done_addr", ifa.mem_address, 32'h010);
        check("wr_done_data", ifa.mem_data,    32'hDEAD_BEEF);
        check("wr_done_ack0", ifa.p0_ack,      32'd0);
        @(negedge clock);
        check("wr_ack0",      ifa.p0_ack,   32'd1);
        check("wr_ack1",      ifa.p1_ack,   32'd0);
        check("wr_ack_busy",  ifa.busy,     32'd0);
        check("wr_ack_wren",  ifa.mem_wren, 32'd0);
        @(negedge clock);
        check("held_ack0",  ifa.p0_ack,   32'd0);
        check("held_busy",  ifa.busy,     32'd0);
        check("held_wren",  ifa.mem_wren, 32'd0);
        ifa.p0_req = 1'b0; ifa.p0_wren = 1'b0;
        @(negedge clock);
        check("held_wren2", ifa.mem_wren, 32'd0);

        // p1 read-back of 0x010
        ifa.p1_req = 1'b1; ifa.p1_wren = 1'b0; ifa.p1_address = 12'h010;
        @(negedge clock);
        check("rd_issue_wren", ifa.mem_wren,    32'd0);
        check("rd_issue_addr", ifa.mem_address, 32'h010);
        @(negedge clock);
        @(negedge clock);
        check("rd_ack1", ifa.p1_ack, 32'd1);
        check("rd_q1",   ifa.p1_q,   32'hDEAD_BEEF);
        check("rd_ack0", ifa.p0_ack, 32'd0);
        check("rd_q0",   ifa.p0_q,   32'd0);
        ifa.p1_req = 1'b0;
        @(negedge clock);

        // reset during ISSUE of a p0 write to 0x020
        ifa.p0_req = 1'b1; ifa.p0_wren = 1'b1; ifa.p0_address = 12'h020; ifa.p0_data = 32'h1234_5678;
        @(negedge clock);
        check("abort_issue_wren", ifa.mem_wren, 32'd1);
        reset = 1'b1; ifa.p0_req = 1'b0; ifa.p0_wren = 1'b0;
        #1;
        check("abort_wren_rst", ifa.mem_wren, 32'd0);
        @(negedge clock);
        check("abort_busy", ifa.busy,     32'd0);
        check("abort_wren", ifa.mem_wren, 32'd0);
        reset = 1'b0;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            ack_seen = ack_seen | ifa.p0_ack;
        end
        check("abort_noack", ack_seen, 32'd0);
        ifa.p1_req = 1'b1; ifa.p1_wren = 1'b0; ifa.p1_address = 12'h020;
        repeat (3) @(negedge clock);
        check("abort_rd_ack1", ifa.p1_ack, 32'd1);
        check("abort_rd_q1",   ifa.p1_q,   32'h1000_0020);
        ifa.p1_req = 1'b0;
        @(negedge clock);

        // both ports request continuously from reset
        reset = 1'b1;
        ifa.p0_req = 1'b1; ifa.p0_wren = 1'b0; ifa.p0_address = 12'h001;
        ifa.p1_req = 1'b1; ifa.p1_wren = 1'b0; ifa.p1_address = 12'h002;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tr_a = '0;
        tr_b = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            tr_a = {tr_a[21:0], ifa.p1_ack, ifa.p0_ack};
            tr_b = {tr_b[21:0], ifb.p1_ack, ifb.p0_ack};
        end
        ifa.p0_req = 1'b0; ifa.p1_req = 1'b0;
        check("rr_trace", {8'h0, tr_a}, 32'h0004_2042);
        check("fp_trace", {8'h0, tr_b}, 32'h0004_2042);
        check("rr_q0", ifa.p0_q, 32'h1000_0001);
        check("rr_q1", ifa.p1_q, 32'h1000_0002);
        @(negedge clock);

        // p0 served alone, then a tie: round-robin favours p1, fixed priority p0
        ifa.p0_req = 1'b1; ifa.p0_wren = 1'b0; ifa.p0_address = 12'h003;
        repeat (3) @(negedge clock);
        check("solo_ack0", ifa.p0_ack, 32'd1);
        ifa.p0_req = 1'b0;
        @(negedge clock);
        ifa.p0_req = 1'b1; ifa.p0_address = 12'h004;
        ifa.p1_req = 1'b1; ifa.p1_address = 12'h005;
        repeat (3) @(negedge clock);
        check("tie_rr", {30'h0, ifa.p1_ack, ifa.p0_ack}, 32'd2);
        check("tie_fp", {30'h0, ifb.p1_ack, ifb.p0_ack}, 32'd1);
        check("tie_rr_q1", ifa.p1_q, 32'h1000_0005);
        check("tie_fp_q0", ifb.p0_q, 32'h1000_0004);
        ifa.p0_req = 1'b0; ifa.p1_req = 1'b0;
        @(negedge clock);
        check("drop_busy_rr", ifa.busy, 32'd0);
        check("drop_busy_fp", ifb.busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
